seq_chunk_adder: RTL and testbench

- Parametrised, multi-cycle successor to the fixed 4-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, reusing one CHUNK-bit ripple slice.
- The carry is registered between chunks.
- Used where wide add/sub must meet timing with small area; start/busy/done handshake to a controlling FSM.

---
 rtl/seq_chunk_adder_if.sv | 27 ++
 rtl/seq_chunk_adder.sv | 107 ++++++++++
 tb/tb_seq_chunk_adder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/seq_chunk_adder_if.sv
// Handshake and operand/result bundle for seq_chunk_adder.
interface seq_chunk_adder_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Sum;
   logic             Cout;
   logic             Ovf;

   // Controller side: issues requests, observes status and results.
   modport master (
      output start, A, B, Cin, sub,
      input  busy, done, Sum, Cout, Ovf
   );

   // Adder side.
   modport slave (
      input  start, A, B, Cin, sub,
      output busy, done, Sum, Cout, Ovf
   );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit add/subtract built from one CHUNK-bit ripple slice,
// carry registered between chunks, start/busy/done handshake.
module seq_chunk_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic               clk,
   input logic               rst,
   seq_chunk_adder_if.slave  bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q, b_q;     // b_q holds the effective (possibly inverted) B
   logic [WIDTH-1:0] acc_q, acc_nxt;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q, ovf_q;

   logic             load, last;
   logic [CHUNK-1:0] a_ch, b_ch, ps;
   logic             cout_ch;
   int unsigned      base;

   // Chunk slice: select the current chunk, ripple-add it, and merge into the accumulator.
   always_comb begin
      base    = int'(cnt_q) * CHUNK;
      a_ch    = a_q[base +: CHUNK];
      b_ch    = b_q[base +: CHUNK];
      {cout_ch, ps} = {1'b0, a_ch} + {1'b0, b_ch} + (CHUNK + 1)'(carry_q);
      acc_nxt = acc_q;
      acc_nxt[base +: CHUNK] = ps;
      last    = (cnt_q == CW'(NCHUNK - 1));
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            bus.busy = 1'b1;
            if (last) state_d = S_DONE;
         end
         S_DONE: begin
            bus.done = 1'b1;
            if (bus.start) begin
               load    = 1'b1;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Operand capture, per-chunk accumulation, and result load on the final chunk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (load) begin
         a_q     <= bus.A;
         b_q     <= bus.sub ? ~bus.B : bus.B;
         carry_q <= bus.sub ? 1'b1 : bus.Cin;
         cnt_q   <= '0;
      end else if (state_q == S_RUN) begin
         acc_q   <= acc_nxt;
         carry_q <= cout_ch;
         cnt_q   <= cnt_q + CW'(1);
         if (last) begin
            sum_q  <= acc_nxt;
            cout_q <= cout_ch;
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_nxt[WIDTH-1] != a_q[WIDTH-1]);
         end
      end
   end

   assign bus.Sum  = sum_q;
   assign bus.Cout = cout_q;
   assign bus.Ovf  = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: 16/4 main instance plus an 8/8 single-chunk instance.
module tb_seq_chunk_adder;
   localparam int W = 16;
   localparam int N = 4;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   logic [W-1:0] last_sum = '0;

   seq_chunk_adder_if #(.WIDTH(16)) ifc ();
   seq_chunk_adder_if #(.WIDTH(8))  ifc8 ();

   seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (ifc8.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive a request in the current cycle and push the reference result.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic s);
      logic [W-1:0] effb;
      logic         c0;
      logic [W:0]   full;
      exp_t         e;
      effb = s ? ~b : b;
      c0   = s ? 1'b1 : cin;
      full = {1'b0, a} + {1'b0, effb} + {{W{1'b0}}, c0};
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (a[W-1] == effb[W-1]) && (full[W-1] != a[W-1]);
      sb.push_back(e);
      ifc.start = 1'b1;
      ifc.A     = a;
      ifc.B     = b;
      ifc.Cin   = cin;
      ifc.sub   = s;
   endtask

   // Step through RUN (scrambling operands, optionally holding start) and check the DONE cycle.
   task automatic run_and_check(input logic hold);
      exp_t e;
      for (int c = 1; c <= N; c++) begin
         @(negedge clk);
         ifc.start = hold;
         ifc.A     = 16'($urandom);
         ifc.B     = 16'($urandom);
         ifc.Cin   = 1'($urandom);
         ifc.sub   = 1'($urandom);
         chk("run_busy", 32'(ifc.busy), 32'd1);
         chk("run_done", 32'(ifc.done), 32'd0);
         chk("run_sum_hold", 32'(ifc.Sum), 32'(last_sum));
      end
      @(negedge clk);
      ifc.start = 1'b0;
      chk("done_pulse", 32'(ifc.done), 32'd1);
      chk("done_busy", 32'(ifc.busy), 32'd0);
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("sum", 32'(ifc.Sum), 32'(e.sum));
         chk("cout", 32'(ifc.Cout), 32'(e.cout));
         chk("ovf", 32'(ifc.Ovf), 32'(e.ovf));
         last_sum = e.sum;
      end
   endtask

   initial begin
      rst = 1'b1;
      ifc.start = 1'b0; ifc.A = '0; ifc.B = '0; ifc.Cin = 1'b0; ifc.sub = 1'b0;
      ifc8.start = 1'b0; ifc8.A = '0; ifc8.B = '0; ifc8.Cin = 1'b0; ifc8.sub = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_busy", 32'(ifc.busy), 32'd0);
      chk("rst_done", 32'(ifc.done), 32'd0);
      chk("rst_sum", 32'(ifc.Sum), 32'd0);
      chk("rst_cout", 32'(ifc.Cout), 32'd0);
      chk("rst_ovf", 32'(ifc.Ovf), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", 32'(ifc.busy), 32'd0);

      // Carry ripples through every chunk
      start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      run_and_check(1'b0);
      @(negedge clk);
      chk("idle_after_done", 32'(ifc.done), 32'd0);
      chk("idle_sum_hold", 32'(ifc.Sum), 32'(last_sum));

      // Add with Cin, then back-to-back signed overflow
      start_op(16'h1234, 16'h4321, 1'b1, 1'b0);
      run_and_check(1'b0);
      start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      run_and_check(1'b0);

      // Subtracts; Cin ignored on the first
      @(negedge clk);
      start_op(16'h0005, 16'h0007, 1'b1, 1'b1);
      run_and_check(1'b0);
      @(negedge clk);
      start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
      run_and_check(1'b1);
      // start held through RUN, then new request in the DONE cycle
      start_op(16'h00F0, 16'h0F0F, 1'b0, 1'b0);
      run_and_check(1'b1);

      // Asynchronous reset during RUN cycle 2
      @(negedge clk);
      ifc.start = 1'b1; ifc.A = 16'hAAAA; ifc.B = 16'h5555; ifc.Cin = 1'b1; ifc.sub = 1'b0;
      @(negedge clk);
      ifc.start = 1'b0;
      @(negedge clk);
      chk("abort_busy_pre", 32'(ifc.busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", 32'(ifc.busy), 32'd0);
      chk("abort_done", 32'(ifc.done), 32'd0);
      chk("abort_sum", 32'(ifc.Sum), 32'd0);
      chk("abort_cout", 32'(ifc.Cout), 32'd0);
      chk("abort_ovf", 32'(ifc.Ovf), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      last_sum = '0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("abort_no_done", 32'(ifc.done), 32'd0);
         chk("abort_idle", 32'(ifc.busy), 32'd0);
      end
      start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
      run_and_check(1'b0);
      chk("post_reset_sum", 32'(last_sum), 32'h0002);

      // Single-chunk configuration
      @(negedge clk);
      ifc8.start = 1'b1; ifc8.A = 8'hFF; ifc8.B = 8'h01; ifc8.Cin = 1'b0; ifc8.sub = 1'b0;
      @(negedge clk);
      ifc8.start = 1'b0; ifc8.A = 8'h00; ifc8.B = 8'h00;
      chk("w8_busy", 32'(ifc8.busy), 32'd1);
      chk("w8_done_early", 32'(ifc8.done), 32'd0);
      @(negedge clk);
      chk("w8_done", 32'(ifc8.done), 32'd1);
      chk("w8_sum", 32'(ifc8.Sum), 32'h00);
      chk("w8_cout", 32'(ifc8.Cout), 32'd1);
      chk("w8_ovf", 32'(ifc8.Ovf), 32'd0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
